proc_mem_responder: RTL and testbench

Memory-side responder for the processor's load/store data port. Accepts one request at a time over a valid/ready handshake and holds it for a programmable number of wait cycles. It then commits the write or performs the read against an internal word-addressed RAM, and returns a response over a second valid/ready handshake. It sits between `Processor` and the data storage, and gives the bench and core a realistic multi-cycle memory.

---
 rtl/proc_mem_responder_if.sv | 26 ++
 rtl/proc_mem_responder.sv | 127 ++++++++++++
 tb/tb_proc_mem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_mem_responder_if.sv
// Load/store data-port bundle between the processor (master) and the memory responder (slave).
interface proc_mem_responder_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/proc_mem_responder.sv
// Multi-cycle memory responder: accepts one request, waits LATENCY cycles, commits the
// access to a word-addressed RAM and holds the response until the processor takes it.
module proc_mem_responder #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst,
   proc_mem_responder_if.slave bus,
   output logic                busy
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LAT4  = 4'(LATENCY);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NB-1:0]       be_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                accept;
   logic                commit;
   logic                in_range;
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic [NB-1:0]       acc_be;
   logic [IDX_W-1:0]    idx;

   // With LATENCY = 0 the access happens on the accept edge, before the capture regs load.
   always_comb begin
      if (state_q == StIdle) begin
         acc_we    = bus.req_we;
         acc_addr  = bus.req_addr;
         acc_wdata = bus.req_wdata;
         acc_be    = bus.req_be;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
      in_range = 32'(acc_addr) < DEPTH;
      idx      = acc_addr[IDX_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.req_valid && !rst) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = LAT4;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StResp;
         end
         StResp: begin
            if (bus.rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      commit = (state_d == StResp) && (state_q != StResp);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
         end
         if (commit) begin
            err_q   <= !in_range;
            rdata_q <= (!acc_we && in_range) ? mem[idx] : '0;
         end else if (state_q == StResp && bus.rsp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
         end
      end
   end

   // RAM contents survive reset; only the write path is gated by it.
   always_ff @(posedge clk) begin
      if (!rst && commit && acc_we && in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = (state_q == StIdle) && !rst;
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: four instances cover LATENCY 2/4/0/15 and DEPTH 200.
module tb_proc_mem_responder;
   localparam int unsigned L0 = 2,   L1 = 4,   L2 = 0,   L3 = 15;
   localparam int unsigned D0 = 200, D1 = 256, D2 = 256, D3 = 256;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          sel;
   logic        req_valid, req_we, rsp_ready;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        busy0, busy1, busy2, busy3;
   logic        cur_req_ready, cur_rsp_valid, cur_err, cur_busy;
   logic [31:0] cur_rdata;

   exp_t        sb_q[$];
   bit   [31:0] model [4][256];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] got;

   always #5 clk = ~clk;

   proc_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) b0 ();
   proc_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) b1 ();
   proc_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) b2 ();
   proc_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) b3 ();

   assign b0.req_valid = req_valid && (sel == 0);
   assign b1.req_valid = req_valid && (sel == 1);
   assign b2.req_valid = req_valid && (sel == 2);
   assign b3.req_valid = req_valid && (sel == 3);
   assign {b0.req_we, b1.req_we, b2.req_we, b3.req_we} = {4{req_we}};
   assign {b0.req_addr, b1.req_addr, b2.req_addr, b3.req_addr} = {4{req_addr}};
   assign {b0.req_wdata, b1.req_wdata, b2.req_wdata, b3.req_wdata} = {4{req_wdata}};
   assign {b0.req_be, b1.req_be, b2.req_be, b3.req_be} = {4{req_be}};
   assign {b0.rsp_ready, b1.rsp_ready, b2.rsp_ready, b3.rsp_ready} = {4{rsp_ready}};

   proc_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(D0), .LATENCY(L0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(b0), .busy(busy0));
   proc_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(D1), .LATENCY(L1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(b1), .busy(busy1));
   proc_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(D2), .LATENCY(L2)) u_dut2 (
      .clk(clk), .rst(rst), .bus(b2), .busy(busy2));
   proc_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(D3), .LATENCY(L3)) u_dut3 (
      .clk(clk), .rst(rst), .bus(b3), .busy(busy3));

   always_comb begin
      cur_req_ready = b0.req_ready;
      cur_rsp_valid = b0.rsp_valid;
      cur_rdata     = b0.rsp_rdata;
      cur_err       = b0.rsp_err;
      cur_busy      = busy0;
      case (sel)
         1: begin
            cur_req_ready = b1.req_ready; cur_rsp_valid = b1.rsp_valid;
            cur_rdata = b1.rsp_rdata; cur_err = b1.rsp_err; cur_busy = busy1;
         end
         2: begin
            cur_req_ready = b2.req_ready; cur_rsp_valid = b2.rsp_valid;
            cur_rdata = b2.rsp_rdata; cur_err = b2.rsp_err; cur_busy = busy2;
         end
         3: begin
            cur_req_ready = b3.req_ready; cur_rsp_valid = b3.rsp_valid;
            cur_rdata = b3.rsp_rdata; cur_err = b3.rsp_err; cur_busy = busy3;
         end
         default: ;
      endcase
   end

   function automatic int unsigned lat_of(input int s);
      case (s)
         0: return L0;
         1: return L1;
         2: return L2;
         default: return L3;
      endcase
   endfunction

   function automatic int unsigned dep_of(input int s);
      case (s)
         0: return D0;
         1: return D1;
         2: return D2;
         default: return D3;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got_v, exp_v, $time);
      else n_pass++;
   endtask

   task automatic model_write(input int s, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
      for (int i = 0; i < 4; i++) begin
         if (be[i]) model[s][addr][8*i +: 8] = wdata[8*i +: 8];
      end
   endtask

   // One request/response; stall = cycles rsp_ready is held low once the response is up.
   task automatic run_txn(input int s, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int stall,
                          output logic [31:0] rdata_o);
      exp_t e;
      int   lat;
      e.err   = (32'(addr) >= dep_of(s));
      e.rdata = (we || e.err) ? 32'h0 : model[s][addr];
      e.lat   = lat_of(s) + 1;
      @(negedge clk);
      sel = s; req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = (stall == 0);
      check_eq("req_ready_idle", cur_req_ready, 1);
      sb_q.push_back(e);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
      while (!cur_rsp_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      e = sb_q.pop_front();
      check_eq("rsp_latency", lat, e.lat);
      check_eq("rsp_rdata", cur_rdata, e.rdata);
      check_eq("rsp_err", cur_err, e.err);
      check_eq("req_ready_in_resp", cur_req_ready, 0);
      rdata_o = cur_rdata;
      for (int i = 0; i < stall; i++) begin
         req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'hFFFF_FFFF;
         req_be = 4'hF;
         @(posedge clk);
         @(negedge clk);
         check_eq("stall_rsp_valid", cur_rsp_valid, 1);
         check_eq("stall_rdata", cur_rdata, e.rdata);
         check_eq("stall_req_ready", cur_req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("done_rsp_valid", cur_rsp_valid, 0);
      check_eq("done_req_ready", cur_req_ready, 1);
      check_eq("done_busy", cur_busy, 0);
      if (we && !e.err) model_write(s, addr, wdata, be);
   endtask

   // Full-word store, then reset `after` cycles past the accept edge.
   task automatic reset_mid(input int s, input logic [7:0] addr, input logic [31:0] wdata,
                            input int after, input bit commits);
      @(negedge clk);
      sel = s; req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata;
      req_be = 4'hF; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < after; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check_eq("pre_reset_busy", cur_busy, 1);
      check_eq("pre_reset_rsp_valid", cur_rsp_valid, commits);
      rst = 1'b1;
      #1;
      check_eq("mid_reset_busy", cur_busy, 0);
      check_eq("mid_reset_rsp_valid", cur_rsp_valid, 0);
      check_eq("mid_reset_req_ready", cur_req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check_eq("post_reset_req_ready", cur_req_ready, 1);
      if (commits) model_write(s, addr, wdata, 4'hF);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; sel = 0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_be = '0; rsp_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         check_eq("rst_rsp_valid", cur_rsp_valid, 0);
         check_eq("rst_rsp_rdata", cur_rdata, 0);
         check_eq("rst_rsp_err", cur_err, 0);
         check_eq("rst_busy", cur_busy, 0);
         check_eq("rst_req_ready", cur_req_ready, 0);
      end
      sel = 0;
      #2 rst = 1'b0;
      @(negedge clk);
      check_eq("req_ready_after_release", cur_req_ready, 1);

      run_txn(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 0, got);
      run_txn(0, 1'b0, 8'h10, 32'h0, 4'h0, 0, got);
      check_eq("load_deadbeef", got, 32'hDEAD_BEEF);

      run_txn(0, 1'b1, 8'h20, 32'h1234_5678, 4'hF, 0, got);
      run_txn(0, 1'b1, 8'h20, 32'h0000_AB00, 4'b0010, 0, got);
      run_txn(0, 1'b0, 8'h20, 32'h0, 4'h0, 0, got);
      check_eq("partial_word", got, 32'h1234_AB78);
      run_txn(0, 1'b1, 8'h20, 32'hFFFF_FFFF, 4'h0, 0, got);
      run_txn(0, 1'b0, 8'h20, 32'h0, 4'h0, 0, got);
      check_eq("zero_be_store", got, 32'h1234_AB78);

      run_txn(0, 1'b0, 8'h10, 32'h0, 4'h0, 5, got);
      check_eq("stalled_load", got, 32'hDEAD_BEEF);

      run_txn(0, 1'b1, 8'h00, 32'hA5A5_5A5A, 4'hF, 0, got);
      run_txn(0, 1'b1, 8'hF0, 32'hCAFE_F00D, 4'hF, 0, got);
      run_txn(0, 1'b0, 8'hF0, 32'h0, 4'h0, 0, got);
      run_txn(0, 1'b0, 8'h00, 32'h0, 4'h0, 0, got);
      check_eq("addr0_unaffected", got, 32'hA5A5_5A5A);

      run_txn(1, 1'b1, 8'h03, 32'h0, 4'hF, 0, got);
      reset_mid(1, 8'h03, 32'h55, 2, 1'b0);
      run_txn(1, 1'b0, 8'h03, 32'h0, 4'h0, 0, got);
      check_eq("wait_reset_dropped", got, 32'h0);

      reset_mid(0, 8'h30, 32'h77, 3, 1'b1);
      run_txn(0, 1'b0, 8'h30, 32'h0, 4'h0, 0, got);
      check_eq("resp_reset_kept", got, 32'h77);
      run_txn(0, 1'b0, 8'h10, 32'h0, 4'h0, 0, got);

      run_txn(2, 1'b1, 8'h07, 32'h0BAD_F00D, 4'hF, 0, got);
      run_txn(2, 1'b0, 8'h07, 32'h0, 4'h0, 0, got);
      run_txn(3, 1'b1, 8'h09, 32'h1357_9BDF, 4'b1001, 0, got);
      run_txn(3, 1'b0, 8'h09, 32'h0, 4'h0, 0, got);

      check_eq("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
